// File: rtl/frame_cap_pkg.sv
// Package: frame_cap_pkg
// Shared definitions for the frame capture controller.
//   state_t   : 3-bit FSM encoding. state[1:0] keeps the values the existing
//               LED decoder expects (IDLE=00, CAPTURE=01, PRINT=10, ERROR=11);
//               WAIT reuses CAPTURE's low bits and is told apart by bit 2.
//   cap_en_of : whether the upstream serial generator is enabled in a state.
package frame_cap_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'b000,
        CAPTURE = 3'b001,
        PRINT   = 3'b010,
        ERROR   = 3'b011,
        WAIT    = 3'b101
    } state_t;

    // The generator runs while a frame is being taken and while a good frame
    // sits waiting, so a recapture can start without a warm-up gap.
    function automatic logic cap_en_of(input state_t s);
        return (s == CAPTURE) || (s == WAIT);
    endfunction

endpackage

// File: rtl/frame_capture_ctrl_edge.sv
// Module: edge_rise_det
// Rising-edge detector for a slow level signal in the sys_clk domain.
//   clk  : clock
//   rst  : asynchronous, active-low reset (clears the delayed copy)
//   in   : level input
//   rise : high for the single cycle in which in is 1 and was 0 one cycle ago
module edge_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q_reg <= 1'b0;
        end else begin
            in_q_reg <= in;
        end
    end

    // A level held high for many cycles yields exactly one rise.
    assign rise = in & ~in_q_reg;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Module: frame_capture_ctrl
// Serial frame capture and timed replay controller.
// Captures FRAME_LEN bits (one per strobe rising edge), closes the frame on the
// next rising edge while sampling the capturer's error flag, and replays a good
// frame one bit every PRINT_INTERVAL clocks.
// Ports:
//   sys_clk, sys_rst (async, active-low)
//   start_pulse : begin / retry capture      print_pulse : begin replay
//   strobe, data, error : capturer interface (data valid at strobe rise)
//   cap_en      : serial generator enable
//   state       : FSM state (frame_cap_pkg encoding)
//   print_bit   : currently displayed bit    print_idx : bits replayed so far
//   frame_err   : last closed frame reported an error (sticky)
// Build option: define FRAME_CAP_AUTOPRINT_EN to start replay automatically
// when a good frame closes; otherwise replay waits for print_pulse.
module frame_capture_ctrl
    import frame_cap_pkg::*;
#(
    parameter int FRAME_LEN      = 16,
    parameter int IDX_W          = 7,
    parameter int PRINT_INTERVAL = 50000000,
    parameter bit MSB_FIRST      = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start_pulse,
    input  logic             print_pulse,
    input  logic             strobe,
    input  logic             data,
    input  logic             error,
    output logic             cap_en,
    output logic [2:0]       state,
    output logic             print_bit,
    output logic [IDX_W-1:0] print_idx,
    output logic             frame_err
);

    localparam int IV_W  = (PRINT_INTERVAL > 1) ? $clog2(PRINT_INTERVAL) : 1;
    localparam int BIT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [IV_W-1:0]  IV_LAST  = IV_W'(PRINT_INTERVAL - 1);
    localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t           state_reg,     state_next;
    logic [IDX_W-1:0] bit_cnt_reg,   bit_cnt_next;
    logic [IV_W-1:0]  iv_cnt_reg,    iv_cnt_next;
    logic [IDX_W-1:0] print_idx_reg, print_idx_next;
    logic             print_bit_reg, print_bit_next;
    logic             frame_err_reg, frame_err_next;
    logic             buf_reg [FRAME_LEN];
    logic             buf_wr;
    logic             rise;
    logic [BIT_W-1:0] sel;

    edge_rise_det u_strobe_edge (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .in   (strobe),
        .rise (rise)
    );

    // Replay order: print_idx counts bits already shown, so it addresses
    // the next bit from whichever end MSB_FIRST selects.
    assign sel = MSB_FIRST ? BIT_W'(LAST_IDX - print_idx_reg)
                           : print_idx_reg[BIT_W-1:0];

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        iv_cnt_next    = iv_cnt_reg;
        print_idx_next = print_idx_reg;
        print_bit_next = print_bit_reg;
        frame_err_next = frame_err_reg;
        buf_wr         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_pulse) begin
                    state_next   = CAPTURE;
                    bit_cnt_next = '0;
                end
            end

            CAPTURE: begin
                if (rise) begin
                    if (bit_cnt_reg < LEN_IDX) begin
                        buf_wr       = 1'b1;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end else begin
                        // Rise after the last data bit closes the frame.
                        frame_err_next = error;
                        bit_cnt_next   = '0;
                        if (error) begin
                            state_next = ERROR;
                        end else begin
`ifdef FRAME_CAP_AUTOPRINT_EN
                            state_next     = PRINT;
                            iv_cnt_next    = '0;
                            print_idx_next = '0;
`else
                            state_next     = WAIT;
`endif
                        end
                    end
                end
            end

            WAIT: begin
                // A recapture request outranks a simultaneous replay request.
                if (start_pulse) begin
                    state_next   = CAPTURE;
                    bit_cnt_next = '0;
                end else if (print_pulse) begin
                    state_next     = PRINT;
                    iv_cnt_next    = '0;
                    print_idx_next = '0;
                end
            end

            PRINT: begin
                if (iv_cnt_reg == IV_LAST) begin
                    iv_cnt_next = '0;
                    if (print_idx_reg < LEN_IDX) begin
                        print_bit_next = buf_reg[sel];
                        print_idx_next = print_idx_reg + 1'b1;
                    end else begin
                        // One extra interval keeps the last bit on display.
                        state_next     = WAIT;
                        print_idx_next = '0;
                    end
                end else begin
                    iv_cnt_next = iv_cnt_reg + 1'b1;
                end
            end

            ERROR: begin
                if (start_pulse) begin
                    state_next     = CAPTURE;
                    bit_cnt_next   = '0;
                    frame_err_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            iv_cnt_reg    <= '0;
            print_idx_reg <= '0;
            print_bit_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            iv_cnt_reg    <= iv_cnt_next;
            print_idx_reg <= print_idx_next;
            print_bit_reg <= print_bit_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Frame buffer: each bit loads only when the capture counter points at it.
    for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_buf
        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
                buf_reg[gi] <= 1'b0;
            end else if (buf_wr && (bit_cnt_reg == IDX_W'(gi))) begin
                buf_reg[gi] <= data;
            end
        end
    end

    assign cap_en    = cap_en_of(state_reg);
    assign state     = state_reg;
    assign print_bit = print_bit_reg;
    assign print_idx = print_idx_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Testbench for frame_capture_ctrl. Two instances (LSB-first and MSB-first)
// share all inputs; expectations come from a transaction-level model of the
// frame buffer, replay schedule and error flag.
module tb_frame_capture_ctrl;
    import frame_cap_pkg::*;

    localparam int FL = 4;
    localparam int IW = 3;
    localparam int PI = 3;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic start_pulse = 1'b0, print_pulse = 1'b0;
    logic strobe = 1'b0, data = 1'b0, error = 1'b0;

    logic          cap_en0, cap_en1, print_bit0, print_bit1, frame_err0, frame_err1;
    logic [2:0]    state0, state1;
    logic [IW-1:0] print_idx0, print_idx1;

    always #5 sys_clk = ~sys_clk;

    frame_capture_ctrl #(.FRAME_LEN(FL), .IDX_W(IW), .PRINT_INTERVAL(PI), .MSB_FIRST(1'b0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start_pulse(start_pulse), .print_pulse(print_pulse),
        .strobe(strobe), .data(data), .error(error), .cap_en(cap_en0), .state(state0),
        .print_bit(print_bit0), .print_idx(print_idx0), .frame_err(frame_err0));

    frame_capture_ctrl #(.FRAME_LEN(FL), .IDX_W(IW), .PRINT_INTERVAL(PI), .MSB_FIRST(1'b1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start_pulse(start_pulse), .print_pulse(print_pulse),
        .strobe(strobe), .data(data), .error(error), .cap_en(cap_en1), .state(state1),
        .print_bit(print_bit1), .print_idx(print_idx1), .frame_err(frame_err1));

    int checks = 0;
    int failures = 0;

    // Reference model
    state_t        m_state;
    logic          m_ferr;
    logic [FL-1:0] m_buf;
    int            m_pidx;
    logic          m_pbit0, m_pbit1;

`ifdef FRAME_CAP_AUTOPRINT_EN
    localparam bit AUTOPRINT = 1'b1;
`else
    localparam bit AUTOPRINT = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag);
        logic exp_cap;
        exp_cap = (m_state == CAPTURE) || (m_state == WAIT);
        chk({tag, ".state0"}, 32'(state0), 32'(m_state));
        chk({tag, ".state1"}, 32'(state1), 32'(m_state));
        chk({tag, ".cap_en0"}, 32'(cap_en0), 32'(exp_cap));
        chk({tag, ".cap_en1"}, 32'(cap_en1), 32'(exp_cap));
        chk({tag, ".ferr0"}, 32'(frame_err0), 32'(m_ferr));
        chk({tag, ".ferr1"}, 32'(frame_err1), 32'(m_ferr));
        chk({tag, ".pidx0"}, 32'(print_idx0), 32'(m_pidx));
        chk({tag, ".pidx1"}, 32'(print_idx1), 32'(m_pidx));
        chk({tag, ".pbit0"}, 32'(print_bit0), 32'(m_pbit0));
        chk({tag, ".pbit1"}, 32'(print_bit1), 32'(m_pbit1));
    endtask

    function automatic logic coin(input int n);
        return ($urandom_range(0, n - 1) == 0);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic m_reset();
        m_state = IDLE;
        m_ferr  = 1'b0;
        m_buf   = '0;
        m_pidx  = 0;
        m_pbit0 = 1'b0;
        m_pbit1 = 1'b0;
    endtask

    // Key pulses and strobe activity where the current state must ignore them.
    task automatic noisy_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            start_pulse = coin(5);
            print_pulse = coin(5);
            tick();
            start_pulse = 1'b0;
            print_pulse = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        strobe = 1'b0; start_pulse = 1'b0; print_pulse = 1'b0;
        sys_rst = 1'b0;
        #1;
        m_reset();
        check_outs({tag, ".rst"});
        @(negedge sys_clk);
        sys_rst = 1'b1;
        tick();
        check_outs({tag, ".rel"});
        $display("reset %s", tag);
    endtask

    task automatic do_start();
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        if (m_state == ERROR) m_ferr = 1'b0;
        m_state = CAPTURE;
        check_outs("start");
        $display("start -> CAPTURE");
    endtask

    task automatic send_rise(input logic d, input logic e);
        data = d;
        error = e;
        strobe = 1'b1;
        start_pulse = coin(4);
        print_pulse = coin(4);
        tick();
        start_pulse = 1'b0;
        print_pulse = 1'b0;
    endtask

    task automatic release_strobe(input int hold);
        noisy_ticks(hold);
        strobe = 1'b0;
        noisy_ticks($urandom_range(1, 3));
        error = $urandom_range(0, 1);
    endtask

    // Captures FL bits then closes; bit long_i is held high for 10 cycles.
    task automatic capture_frame(input logic [FL-1:0] bits, input logic err, input int long_i);
        for (int i = 0; i < FL; i++) begin
            send_rise(bits[i], coin(3));
            check_outs("cap_bit");
            release_strobe((i == long_i) ? 9 : $urandom_range(0, 3));
        end
        send_rise(logic'($urandom_range(0, 1)), err);
        m_buf  = bits;
        m_ferr = err;
        if (err) m_state = ERROR;
        else if (AUTOPRINT) begin
            m_state = PRINT;
            m_pidx  = 0;
        end else m_state = WAIT;
        check_outs("close");
        strobe = 1'b0;
        error  = 1'b0;
        $display("capture bits(lsb first)=%b%b%b%b err=%0d", bits[0], bits[1], bits[2], bits[3], err);
    endtask

    task automatic replay(input logic use_pulse);
        if (use_pulse) begin
            print_pulse = 1'b1;
            tick();
            print_pulse = 1'b0;
            m_state = PRINT;
            m_pidx  = 0;
            check_outs("pr_entry");
        end
        for (int k = 1; k <= FL; k++) begin
            noisy_ticks(PI);
            m_pidx  = k;
            m_pbit0 = m_buf[k-1];
            m_pbit1 = m_buf[FL-k];
            check_outs("pr_bit");
        end
        noisy_ticks(PI);
        m_state = WAIT;
        m_pidx  = 0;
        check_outs("pr_done");
        $display("replay frame=%b pulse=%0d", m_buf, use_pulse);
    endtask

    task automatic good_close();
        if (AUTOPRINT) replay(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
        check_outs("idle");
    endtask

    initial begin
        logic [FL-1:0] bits;
        logic e;
        m_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check_outs("por");
        @(negedge sys_clk);
        sys_rst = 1'b1;
        tick();
        check_outs("por_rel");

        // Reset in the middle of a capture
        do_start();
        send_rise(1'b1, 1'b0); release_strobe(0);
        send_rise(1'b0, 1'b0); release_strobe(1);
        do_reset("mid_cap");

        // Directed frame 1,0,1,1 replayed twice
        do_start();
        capture_frame(4'b1101, 1'b0, -1);
        good_close();
        replay(1'b1);
        replay(1'b1);

        // Error frame: replay ignored, restart clears the flag
        do_start();
        capture_frame(4'($urandom), 1'b1, -1);
        print_pulse = 1'b1;
        tick();
        print_pulse = 1'b0;
        check_outs("err_print_ign");
        idle(4);
        do_start();
        capture_frame(4'($urandom), 1'b0, 1);
        good_close();

        // Simultaneous start and print in WAIT
        start_pulse = 1'b1;
        print_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        print_pulse = 1'b0;
        m_state = CAPTURE;
        check_outs("both_keys");
        $display("start+print in WAIT -> CAPTURE");
        capture_frame(4'($urandom), 1'b0, $urandom_range(0, FL - 1));
        good_close();

        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0: idle($urandom_range(1, 5));
                1: begin
                    if (m_state == WAIT) replay(1'b1);
                    else idle(2);
                end
                2: begin
                    if (m_state == WAIT) begin
                        print_pulse = 1'b1;
                        tick();
                        print_pulse = 1'b0;
                        repeat ($urandom_range(1, 12)) tick();
                        do_reset("mid_print");
                    end else idle(1);
                end
                default: begin
                    bits = 4'($urandom);
                    e = coin(3);
                    do_start();
                    capture_frame(bits, e, $urandom_range(0, FL));
                    if (!e) good_close();
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
